// File: rtl/fsm_sequence_monitor.sv
// Watches an encoded state stream and checks that it walks 0,1,...,LAST_STATE one step at a time.
// Reports completions, counts them, and latches the first protocol violation with a cause code.
module fsm_sequence_monitor #(
  parameter int STATE_W    = 4,
  parameter int LAST_STATE = 6,
  parameter int TIMEOUT    = 16,
  parameter int CNT_W      = 8
) (
  input  logic               aclk,
  input  logic               aresetn,
  input  logic               enable,
  input  logic               clear,
  input  logic [STATE_W-1:0] state_in,
  output logic               busy,
  output logic               seq_done,
  output logic               seq_error,
  output logic [2:0]         err_code,
  output logic [STATE_W-1:0] err_state,
  output logic [CNT_W-1:0]   step_count,
  output logic [CNT_W-1:0]   seq_count
);

  localparam int DWELL_W = $clog2(TIMEOUT + 1);
  localparam logic [STATE_W-1:0] LAST_CODE   = STATE_W'(LAST_STATE);
  localparam logic [DWELL_W-1:0] DWELL_LIMIT = DWELL_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0]   CNT_MAX     = '1;

  localparam logic [2:0] ERR_ILLEGAL = 3'd1;
  localparam logic [2:0] ERR_RESTART = 3'd2;
  localparam logic [2:0] ERR_TIMEOUT = 3'd3;
  localparam logic [2:0] ERR_RANGE   = 3'd4;

  typedef enum logic [1:0] {WAIT_IDLE, TRACK, DONE, ERROR} state_e;

  state_e             state_q, state_d;
  logic [STATE_W-1:0] prev_q, prev_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [CNT_W-1:0]   step_count_q, step_count_d;
  logic [CNT_W-1:0]   seq_count_q, seq_count_d;
  logic               seq_done_q, seq_done_d;
  logic               seq_error_q, seq_error_d;
  logic [2:0]         err_code_q, err_code_d;
  logic [STATE_W-1:0] err_state_q, err_state_d;
  logic [STATE_W-1:0] prev_plus1;

  assign prev_plus1 = prev_q + 1'b1;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q      <= WAIT_IDLE;
      prev_q       <= '0;
      dwell_q      <= '0;
      step_count_q <= '0;
      seq_count_q  <= '0;
      seq_done_q   <= 1'b0;
      seq_error_q  <= 1'b0;
      err_code_q   <= '0;
      err_state_q  <= '0;
    end else begin
      state_q      <= state_d;
      prev_q       <= prev_d;
      dwell_q      <= dwell_d;
      step_count_q <= step_count_d;
      seq_count_q  <= seq_count_d;
      seq_done_q   <= seq_done_d;
      seq_error_q  <= seq_error_d;
      err_code_q   <= err_code_d;
      err_state_q  <= err_state_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    prev_d       = prev_q;
    dwell_d      = dwell_q;
    step_count_d = step_count_q;
    seq_count_d  = seq_count_q;
    seq_done_d   = 1'b0;
    seq_error_d  = seq_error_q;
    err_code_d   = err_code_q;
    err_state_d  = err_state_q;

    // DONE lasts one cycle whether or not the input is qualified
    if (state_q == DONE) begin
      state_d = WAIT_IDLE;
    end

    if (clear) begin
      state_d      = WAIT_IDLE;
      prev_d       = '0;
      dwell_d      = '0;
      step_count_d = '0;
      seq_error_d  = 1'b0;
      err_code_d   = '0;
      err_state_d  = '0;
    end else if (enable) begin
      case (state_q)
        // DONE samples like WAIT_IDLE so a 0 right after completion starts the next sequence
        WAIT_IDLE, DONE: begin
          if (state_in == '0) begin
            state_d      = TRACK;
            prev_d       = '0;
            dwell_d      = '0;
            step_count_d = '0;
          end
        end
        TRACK: begin
          if (state_in > LAST_CODE) begin
            state_d     = ERROR;
            seq_error_d = 1'b1;
            err_code_d  = ERR_RANGE;
            err_state_d = state_in;
          end else if (state_in == prev_q) begin
            if (dwell_q == DWELL_LIMIT) begin
              state_d     = ERROR;
              seq_error_d = 1'b1;
              err_code_d  = ERR_TIMEOUT;
              err_state_d = state_in;
            end else begin
              dwell_d = dwell_q + 1'b1;
            end
          end else if (state_in == prev_plus1) begin
            prev_d       = state_in;
            dwell_d      = '0;
            step_count_d = step_count_q + 1'b1;
            if (state_in == LAST_CODE) begin
              state_d     = DONE;
              seq_done_d  = 1'b1;
              seq_count_d = (seq_count_q == CNT_MAX) ? seq_count_q : seq_count_q + 1'b1;
            end
          end else begin
            state_d     = ERROR;
            seq_error_d = 1'b1;
            err_code_d  = (state_in == '0) ? ERR_RESTART : ERR_ILLEGAL;
            err_state_d = state_in;
          end
        end
        default: begin
          // ERROR is sticky until clear or reset
        end
      endcase
    end
  end

  assign busy       = (state_q == TRACK);
  assign seq_done   = seq_done_q;
  assign seq_error  = seq_error_q;
  assign err_code   = err_code_q;
  assign err_state  = err_state_q;
  assign step_count = step_count_q;
  assign seq_count  = seq_count_q;

endmodule

// File: tb/tb_fsm_sequence_monitor.sv
// Directed bench for fsm_sequence_monitor: a rule-level model is compared against the DUT every cycle,
// with literal expectations pinning key points of each scenario.
module tb_fsm_sequence_monitor;

  localparam int LAST = 6;
  localparam int TMO  = 16;
  localparam int CMAX = 255;

  logic       aclk = 1'b0;
  logic       aresetn = 1'b0;
  logic       enable = 1'b0;
  logic       clear = 1'b0;
  logic [3:0] state_in = 4'd0;
  logic       busy, seq_done, seq_error;
  logic [2:0] err_code;
  logic [3:0] err_state;
  logic [7:0] step_count, seq_count;

  fsm_sequence_monitor #(
    .STATE_W(4), .LAST_STATE(LAST), .TIMEOUT(TMO), .CNT_W(8)
  ) dut (
    .aclk(aclk), .aresetn(aresetn), .enable(enable), .clear(clear), .state_in(state_in),
    .busy(busy), .seq_done(seq_done), .seq_error(seq_error), .err_code(err_code),
    .err_state(err_state), .step_count(step_count), .seq_count(seq_count)
  );

  always #5 aclk = ~aclk;

  int n_vec = 0;
  int n_fail = 0;

  // Model: tracking flag, errored flag, last accepted code and repeat count.
  bit m_tracking, m_errored;
  int m_last, m_repeats, m_steps, m_seqs, m_done, m_code, m_estate;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_tracking = 0; m_errored = 0; m_last = 0; m_repeats = 0;
    m_steps = 0; m_seqs = 0; m_done = 0; m_code = 0; m_estate = 0;
  endtask

  task automatic model_fail(input int code, input int v);
    m_tracking = 0; m_errored = 1; m_code = code; m_estate = v;
  endtask

  task automatic model_edge(input bit en, input bit clr, input int v);
    m_done = 0;
    if (clr) begin
      m_tracking = 0; m_errored = 0; m_code = 0; m_estate = 0; m_steps = 0; m_repeats = 0;
    end else if (en && !m_errored) begin
      if (!m_tracking) begin
        if (v == 0) begin
          m_tracking = 1; m_last = 0; m_repeats = 0; m_steps = 0;
        end
      end else if (v > LAST) model_fail(4, v);
      else if (v == m_last) begin
        m_repeats++;
        if (m_repeats >= TMO) model_fail(3, v);
      end else if (v == m_last + 1) begin
        m_last = v; m_repeats = 0; m_steps = (m_steps + 1) % 256;
        if (v == LAST) begin
          m_tracking = 0; m_done = 1;
          if (m_seqs < CMAX) m_seqs++;
        end
      end else if (v == 0) model_fail(2, v);
      else model_fail(1, v);
    end
  endtask

  initial model_reset();

  // Compare process: every rising edge, advance the model and check all outputs just after.
  always @(posedge aclk) begin
    if (aresetn === 1'b1) model_edge(enable, clear, int'(state_in));
    #1;
    chk("busy", busy, m_tracking);
    chk("seq_done", seq_done, m_done);
    chk("seq_error", seq_error, m_errored);
    chk("err_code", err_code, m_code);
    chk("err_state", err_state, m_estate);
    chk("step_count", step_count, m_steps);
    chk("seq_count", seq_count, m_seqs);
  end

  task automatic drive(input bit en, input bit clr, input int v);
    @(negedge aclk);
    enable = en; clear = clr; state_in = 4'(v);
    @(posedge aclk);
    #2;
  endtask

  task automatic run_clean();
    for (int v = 0; v <= LAST; v++) drive(1, 0, v);
  endtask

  initial begin
    repeat (2) @(negedge aclk);
    chk("rst_busy", busy, 0);
    chk("rst_seq_done", seq_done, 0);
    chk("rst_seq_error", seq_error, 0);
    chk("rst_err_code", err_code, 0);
    chk("rst_err_state", err_state, 0);
    chk("rst_step_count", step_count, 0);
    chk("rst_seq_count", seq_count, 0);
    aresetn = 1'b1;

    // nonzero codes before the first IDLE are ignored
    drive(1, 0, 5); drive(1, 0, 3);
    chk("pre_idle_err", seq_error, 0);

    // clean sequence
    run_clean();
    chk("t1_done", seq_done, 1);
    chk("t1_steps", step_count, 6);
    chk("t1_seqs", seq_count, 1);
    chk("t1_err", seq_error, 0);
    drive(0, 0, 7);
    chk("t1_done_pulse", seq_done, 0);

    // illegal skip, then clear
    drive(1, 0, 0); drive(1, 0, 1); drive(1, 0, 2);
    chk("t2_busy", busy, 1);
    drive(1, 0, 4);
    chk("t2_err", seq_error, 1);
    chk("t2_code", err_code, 1);
    chk("t2_estate", err_state, 4);
    chk("t2_steps", step_count, 2);
    chk("t2_busy_err", busy, 0);
    drive(1, 1, 0);
    chk("t2_clr_err", seq_error, 0);
    chk("t2_clr_code", err_code, 0);
    chk("t2_clr_seqs", seq_count, 1);

    // timeout after 16 repeats; 15 repeats tolerated
    drive(1, 0, 0); drive(1, 0, 1);
    repeat (15) drive(1, 0, 1);
    chk("t3_no_err_15", seq_error, 0);
    drive(1, 0, 1);
    chk("t3_err", seq_error, 1);
    chk("t3_code", err_code, 3);
    chk("t3_estate", err_state, 1);
    drive(1, 1, 0);
    drive(1, 0, 0); drive(1, 0, 1);
    repeat (15) drive(1, 0, 1);
    for (int v = 2; v <= LAST; v++) drive(1, 0, v);
    chk("t3_ok_done", seq_done, 1);
    chk("t3_ok_err", seq_error, 0);
    chk("t3_ok_seqs", seq_count, 2);

    // restart and out-of-range
    drive(1, 0, 0); drive(1, 0, 1); drive(1, 0, 2); drive(1, 0, 0);
    chk("t4_code_restart", err_code, 2);
    chk("t4_estate_restart", err_state, 0);
    drive(1, 1, 0);
    drive(1, 0, 0); drive(1, 0, 9);
    chk("t4_code_range", err_code, 4);
    chk("t4_estate_range", err_state, 9);
    drive(1, 1, 0);
    // only the first error is kept
    drive(1, 0, 0); drive(1, 0, 3); drive(1, 0, 9);
    chk("t4_first_code", err_code, 1);
    chk("t4_first_estate", err_state, 3);
    drive(1, 1, 0);
    // clear beats a violating sample
    drive(1, 0, 0); drive(1, 0, 1); drive(1, 1, 9);
    chk("t4_clr_wins", seq_error, 0);

    // long enable-low gap does not time out
    drive(1, 0, 0); drive(1, 0, 1); drive(1, 0, 2);
    repeat (40) drive(0, 0, 9);
    for (int v = 3; v <= LAST; v++) drive(1, 0, v);
    chk("t5_done", seq_done, 1);
    chk("t5_steps", step_count, 6);
    chk("t5_err", seq_error, 0);

    // back-to-back sequences saturate seq_count
    repeat (300) run_clean();
    chk("t6_sat", seq_count, 255);
    chk("t6_err", seq_error, 0);

    // asynchronous reset mid-sequence
    drive(1, 0, 0); drive(1, 0, 1); drive(1, 0, 2);
    @(negedge aclk);
    #2 aresetn = 1'b0;
    model_reset();
    #1;
    chk("ar_busy", busy, 0);
    chk("ar_seq_count", seq_count, 0);
    chk("ar_step_count", step_count, 0);
    chk("ar_seq_error", seq_error, 0);
    @(negedge aclk);
    aresetn = 1'b1;
    drive(1, 0, 3); drive(1, 0, 4);
    chk("ar_wait_err", seq_error, 0);
    run_clean();
    chk("ar_seqs", seq_count, 1);

    drive(0, 0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
